// File: rtl/mem_bus_if.sv
// Memory bus bridge between the decoder/datapath and a single external memory port.
// It runs one access at a time with ack-or-timeout completion and a held read-data register.
module mem_bus_if #(
    parameter int TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mem_rd,
    input  logic        i_mem_wr,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_rdata,
    output logic        o_stall,
    output logic        o_err,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [15:0] o_bus_addr,
    output logic [15:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [15:0] i_bus_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          bus_req_q;
    logic          bus_we_q;
    logic [15:0]   bus_addr_q;
    logic [15:0]   bus_wdata_q;
    logic [15:0]   rdata_q;
    logic          err_q;

    logic          busy;
    logic          accept;
    logic          conflict;
    logic          timeout_hit;
    logic          complete;
    logic [15:0]   rdata_d;

    always_comb begin
        busy        = (state_q != IDLE);
        accept      = (state_q == IDLE) && (i_mem_rd ^ i_mem_wr);
        conflict    = (state_q == IDLE) && i_mem_rd && i_mem_wr;
        // Ack wins over a timeout landing in the same cycle.
        timeout_hit = busy && !i_bus_ack && (cnt_q == TMAX);
        complete    = busy && (i_bus_ack || timeout_hit);
        rdata_d     = rdata_q;
        if (state_q == RD && i_bus_ack)
            rdata_d = i_bus_rdata;
        else if (state_q == RD && timeout_hit)
            rdata_d = 16'hFFFF;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (conflict) begin
                        err_q <= 1'b1;
                    end else if (accept) begin
                        state_q    <= i_mem_rd ? RD : WR;
                        bus_req_q  <= 1'b1;
                        bus_we_q   <= i_mem_wr;
                        bus_addr_q <= i_addr;
                        cnt_q      <= '0;
                        if (i_mem_wr)
                            bus_wdata_q <= i_wdata;
                    end
                end
                RD, WR: begin
                    if (complete) begin
                        state_q   <= IDLE;
                        bus_req_q <= 1'b0;
                        err_q     <= timeout_hit;
                        if (state_q == RD)
                            rdata_q <= rdata_d;
                    end else if (cnt_q != TMAX) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_stall     = accept || (busy && !complete);
    assign o_rdata     = rdata_d;
    assign o_err       = err_q;
    assign o_bus_req   = bus_req_q;
    assign o_bus_we    = bus_we_q;
    assign o_bus_addr  = bus_addr_q;
    assign o_bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_bus_if.sv
// Directed bench for mem_bus_if with TIMEOUT=4. Inputs change 1ns after the rising edge.
// Outputs are checked 2ns after the rising edge.
module tb_mem_bus_if;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] wdata = '0;
    logic [15:0] rdata;
    logic        stall;
    logic        err;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [15:0] bus_rdata = '0;

    int checks = 0;
    int errors = 0;

    mem_bus_if #(.TIMEOUT(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_mem_rd    (mem_rd),
        .i_mem_wr    (mem_wr),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_rdata     (rdata),
        .o_stall     (stall),
        .o_err       (err),
        .o_bus_req   (bus_req),
        .o_bus_we    (bus_we),
        .o_bus_addr  (bus_addr),
        .o_bus_wdata (bus_wdata),
        .i_bus_ack   (bus_ack),
        .i_bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus_req); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h want 0000", rdata); end
        checks++; if (bus_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", bus_addr); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        tick();
        rst = 1'b0;
        tick();
        $display("reset: done");
    endtask

    task automatic test_read_wait();
        mem_rd = 1'b1; addr = 16'h0100; bus_rdata = 16'hBEEF; bus_ack = 1'b0;
        #1;
        checks++; if (stall !== 1'b1 || bus_req !== 1'b0) begin errors++; $display("FAIL rd_accept: stall=%b req=%b want 1 0", stall, bus_req); end
        for (int i = 0; i < 2; i++) begin
            tick();
            #1;
            checks++; if (stall !== 1'b1 || bus_req !== 1'b1 || bus_we !== 1'b0 || bus_addr !== 16'h0100)
                begin errors++; $display("FAIL rd_wait%0d: stall=%b req=%b we=%b addr=%h want 1 1 0 0100", i, stall, bus_req, bus_we, bus_addr); end
        end
        tick();
        bus_ack = 1'b1;
        #1;
        checks++; if (stall !== 1'b0 || bus_req !== 1'b1 || rdata !== 16'hBEEF)
            begin errors++; $display("FAIL rd_ack: stall=%b req=%b rdata=%h want 0 1 beef", stall, bus_req, rdata); end
        tick();
        mem_rd = 1'b0; bus_ack = 1'b0; bus_rdata = 16'h0000;
        #1;
        checks++; if (rdata !== 16'hBEEF || bus_req !== 1'b0 || err !== 1'b0 || stall !== 1'b0)
            begin errors++; $display("FAIL rd_hold: rdata=%h req=%b err=%b stall=%b want beef 0 0 0", rdata, bus_req, err, stall); end
        $display("read_wait: addr 0100 data beef");
    endtask

    task automatic test_write_zero_wait();
        mem_wr = 1'b1; addr = 16'h2000; wdata = 16'h1234; bus_ack = 1'b1;
        #1;
        checks++; if (stall !== 1'b1 || bus_req !== 1'b0) begin errors++; $display("FAIL wr_accept: stall=%b req=%b want 1 0", stall, bus_req); end
        tick();
        addr = 16'hFFFF; wdata = 16'h0000;
        #1;
        checks++; if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 16'h2000 || bus_wdata !== 16'h1234 || stall !== 1'b0)
            begin errors++; $display("FAIL wr_bus: req=%b we=%b addr=%h wdata=%h stall=%b want 1 1 2000 1234 0", bus_req, bus_we, bus_addr, bus_wdata, stall); end
        tick();
        mem_wr = 1'b0; bus_ack = 1'b0;
        #1;
        checks++; if (bus_req !== 1'b0 || err !== 1'b0 || rdata !== 16'hBEEF)
            begin errors++; $display("FAIL wr_done: req=%b err=%b rdata=%h want 0 0 beef", bus_req, err, rdata); end
        $display("write_zero_wait: addr 2000 data 1234");
    endtask

    task automatic test_timeout();
        mem_rd = 1'b1; addr = 16'h0300; bus_ack = 1'b0; bus_rdata = 16'h5A5A;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL to_accept: stall=%b want 1", stall); end
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            checks++; if (stall !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL to_wait%0d: stall=%b err=%b want 1 0", i, stall, err); end
        end
        tick();
        #1;
        checks++; if (stall !== 1'b0 || rdata !== 16'hFFFF || bus_req !== 1'b1)
            begin errors++; $display("FAIL to_hit: stall=%b rdata=%h req=%b want 0 ffff 1", stall, rdata, bus_req); end
        tick();
        mem_rd = 1'b0;
        #1;
        checks++; if (err !== 1'b1 || bus_req !== 1'b0 || rdata !== 16'hFFFF)
            begin errors++; $display("FAIL to_err: err=%b req=%b rdata=%h want 1 0 ffff", err, bus_req, rdata); end
        tick();
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_once: err=%b want 0", err); end
        $display("timeout: read 0300 aborted with ffff");
    endtask

    task automatic test_conflict_and_idle_ack();
        mem_rd = 1'b1; mem_wr = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL both_stall: got %b want 0", stall); end
        tick();
        mem_rd = 1'b0; mem_wr = 1'b0;
        #1;
        checks++; if (err !== 1'b1 || bus_req !== 1'b0) begin errors++; $display("FAIL both_err: err=%b req=%b want 1 0", err, bus_req); end
        tick();
        bus_ack = 1'b1;
        #1;
        checks++; if (err !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL both_once: err=%b stall=%b want 0 0", err, stall); end
        tick();
        bus_ack = 1'b0;
        #1;
        checks++; if (bus_req !== 1'b0 || err !== 1'b0 || stall !== 1'b0)
            begin errors++; $display("FAIL idle_ack: req=%b err=%b stall=%b want 0 0 0", bus_req, err, stall); end
        $display("conflict_and_idle_ack: one err pulse, ack ignored");
    endtask

    task automatic test_back_to_back();
        mem_rd = 1'b1; addr = 16'h0400; bus_rdata = 16'h1111; bus_ack = 1'b1;
        tick();
        #1;
        checks++; if (bus_req !== 1'b1 || bus_addr !== 16'h0400 || rdata !== 16'h1111 || stall !== 1'b0)
            begin errors++; $display("FAIL b2b_first: req=%b addr=%h rdata=%h stall=%b want 1 0400 1111 0", bus_req, bus_addr, rdata, stall); end
        tick();
        addr = 16'h0500; bus_rdata = 16'h2222;
        #1;
        checks++; if (bus_req !== 1'b0 || stall !== 1'b1 || rdata !== 16'h1111)
            begin errors++; $display("FAIL b2b_gap: req=%b stall=%b rdata=%h want 0 1 1111", bus_req, stall, rdata); end
        tick();
        #1;
        checks++; if (bus_req !== 1'b1 || bus_addr !== 16'h0500 || rdata !== 16'h2222)
            begin errors++; $display("FAIL b2b_second: req=%b addr=%h rdata=%h want 1 0500 2222", bus_req, bus_addr, rdata); end
        tick();
        mem_rd = 1'b0; bus_ack = 1'b0;
        #1;
        checks++; if (bus_req !== 1'b0 || rdata !== 16'h2222) begin errors++; $display("FAIL b2b_end: req=%b rdata=%h want 0 2222", bus_req, rdata); end
        $display("back_to_back: 0400->1111 0500->2222");
    endtask

    task automatic test_reset_mid_write();
        mem_wr = 1'b1; addr = 16'h0600; wdata = 16'h5555; bus_ack = 1'b0;
        tick();
        #1;
        checks++; if (bus_req !== 1'b1 || bus_we !== 1'b1) begin errors++; $display("FAIL rstw_busy: req=%b we=%b want 1 1", bus_req, bus_we); end
        mem_wr = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (bus_req !== 1'b0 || bus_we !== 1'b0 || err !== 1'b0 || stall !== 1'b0 || rdata !== 16'h0000)
            begin errors++; $display("FAIL rstw_abort: req=%b we=%b err=%b stall=%b rdata=%h want 0 0 0 0 0000", bus_req, bus_we, err, stall, rdata); end
        tick();
        rst = 1'b0;
        tick();
        #1;
        checks++; if (err !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("FAIL rstw_quiet: err=%b req=%b want 0 0", err, bus_req); end
        mem_rd = 1'b1; addr = 16'h0700; bus_rdata = 16'h3333;
        tick();
        #1;
        checks++; if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_addr !== 16'h0700 || stall !== 1'b1)
            begin errors++; $display("FAIL rstw_rd: req=%b we=%b addr=%h stall=%b want 1 0 0700 1", bus_req, bus_we, bus_addr, stall); end
        bus_ack = 1'b1;
        #1;
        checks++; if (stall !== 1'b0 || rdata !== 16'h3333) begin errors++; $display("FAIL rstw_ack: stall=%b rdata=%h want 0 3333", stall, rdata); end
        tick();
        mem_rd = 1'b0; bus_ack = 1'b0;
        #1;
        checks++; if (rdata !== 16'h3333 || err !== 1'b0 || bus_req !== 1'b0)
            begin errors++; $display("FAIL rstw_end: rdata=%h err=%b req=%b want 3333 0 0", rdata, err, bus_req); end
        $display("reset_mid_write: aborted, next read 0700->3333");
    endtask

    initial begin
        #1;
        test_reset();
        test_read_wait();
        test_write_zero_wait();
        test_timeout();
        test_conflict_and_idle_ack();
        test_back_to_back();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
